// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: byte width, drain FSM state
// encodings and status-register bit positions used by the bus interface.
package uart_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    // Transmit drain FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } drain_state_e;

    // Status register bit positions; full/overflow extend the original map
    localparam int unsigned STAT_TX_BUSY_BIT  = 0;
    localparam int unsigned STAT_RX_VALID_BIT = 1;
    localparam int unsigned STAT_TX_FULL_BIT  = 2;
    localparam int unsigned STAT_TX_OVF_BIT   = 3;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array for the transmit FIFO.
// Ports:
//   clk   - clock
//   we    - synchronous write enable
//   waddr - write address
//   wdata - write data
//   raddr - asynchronous read address
//   rdata - read data (combinational from raddr)
module fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the CPU write path and the UART serializer. Buffers
// byte writes and drains them one at a time through the latch/busy handshake.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   wr_en     - single-cycle write strobe
//   wr_data   - byte to enqueue
//   ovf_clr   - clears the sticky overflow flag
//   full      - occupancy equals depth
//   empty     - occupancy is zero
//   count     - occupancy, 0..DEPTH
//   overflow  - sticky: a write arrived while full
//   tx_data   - byte presented to the serializer
//   tx_latch  - one-cycle load pulse to the serializer
//   tx_busy   - serializer busy, rises the cycle after an accepted latch
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ovf_clr,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_latch,
    input  logic                  tx_busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_accept;
    logic                  pop;
    logic                  latch_d;
    drain_state_e          state_q;
    drain_state_e          state_d;

    // Status derived from the registered occupancy
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign wr_accept = wr_en && !full;

    fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Drain FSM next-state: pop only from IDLE with the serializer free
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        latch_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop     = 1'b1;
                    latch_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain FSM state and serializer outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tx_latch <= 1'b0;
            tx_data  <= '0;
        end else begin
            state_q  <= state_d;
            tx_latch <= latch_d;
            if (pop) begin
                tx_data <= rd_data;
            end
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow; a rejected write beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven vectors plus
// hand-written handshake, wrap and reset sequences.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int          BUSY_TICKS = 12;

    logic                clk;
    logic                rst;
    logic                wr_en;
    logic [7:0]          wr_data;
    logic                ovf_clr;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic [7:0]          tx_data;
    logic                tx_latch;
    logic                tx_busy;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_latch (tx_latch),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] feed_q[$];

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       ovf_clr;
        logic       busy;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       latch;
        logic       chk_data;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic w, input logic [7:0] d, input logic oc,
                                input logic b, input logic [4:0] c, input logic f,
                                input logic e, input logic o, input logic l,
                                input logic cd, input logic [7:0] dd);
        vec_t v;
        v.wr_en = w;  v.wr_data = d; v.ovf_clr = oc; v.busy = b;
        v.cnt = c;    v.full = f;    v.empty = e;    v.ovf = o;
        v.latch = l;  v.chk_data = cd; v.data = dd;
        vecs.push_back(v);
    endfunction

    // Serializer model: busy rises the cycle after a latch and holds BUSY_TICKS
    // cycles. Optionally feeds feed_q into the FIFO whenever it is not full.
    task automatic serve(input int n, input string tag);
        int   got      = 0;
        int   busy_cnt = 0;
        int   fall_cyc = -1;
        int   idle     = 0;
        int   c        = 0;
        int   max_c    = n * 16 + 100;
        logic lat;
        logic prev_busy;
        while (c < max_c && idle < 20) begin
            if (feed_q.size() > 0 && !full) begin
                wr_en   = 1'b1;
                wr_data = feed_q.pop_front();
            end else begin
                wr_en = 1'b0;
            end
            lat       = tx_latch;
            prev_busy = tx_busy;
            step();
            c++;
            if (lat) busy_cnt = BUSY_TICKS;
            tx_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (prev_busy && !tx_busy) fall_cyc = c;
            if (tx_latch) begin
                chk($sformatf("%s busy_at_latch", tag), 32'(tx_busy), 0);
                if (fall_cyc >= 0) begin
                    chk($sformatf("%s gap", tag), 32'(c - fall_cyc), 2);
                    fall_cyc = -1;
                end
                if (exp_q.size() > 0)
                    chk($sformatf("%s data%0d", tag, got), 32'(tx_data), 32'(exp_q.pop_front()));
                else
                    chk($sformatf("%s extra_latch", tag), 32'(got + 1), 32'(n));
                got++;
            end
            if (got >= n && busy_cnt == 0 && feed_q.size() == 0) idle++;
        end
        wr_en = 1'b0;
        chk($sformatf("%s latches", tag), 32'(got), 32'(n));
        chk($sformatf("%s count", tag), 32'(count), 0);
        chk($sformatf("%s empty", tag), 32'(empty), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nlat;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0; tx_busy = 1'b0;

        // Vector table: inputs for one cycle, outputs sampled after the edge
        add(1, 8'hA5, 0, 0,  1, 0, 0, 0, 0, 1, 8'h00);
        add(0, 8'h00, 0, 0,  0, 0, 1, 0, 1, 1, 8'hA5);
        add(0, 8'h00, 0, 0,  0, 0, 1, 0, 0, 1, 8'hA5);
        add(0, 8'h00, 0, 0,  0, 0, 1, 0, 0, 1, 8'hA5);
        for (int k = 0; k < 16; k++)
            add(1, 8'(k + 1), 0, 1, 5'(k + 1), (k == 15), 0, 0, 0, 1, 8'hA5);
        add(1, 8'hFF, 0, 1, 16, 1, 0, 1, 0, 1, 8'hA5);
        add(1, 8'hFF, 1, 1, 16, 1, 0, 1, 0, 1, 8'hA5);
        add(0, 8'h00, 1, 1, 16, 1, 0, 0, 0, 1, 8'hA5);
        add(1, 8'hEE, 0, 0, 15, 0, 0, 1, 1, 1, 8'h01);
        add(0, 8'h00, 1, 1, 15, 0, 0, 0, 0, 1, 8'h01);

        step(); step();
        rst = 1'b0;
        chk("rst count", 32'(count), 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst full", 32'(full), 0);
        chk("rst overflow", 32'(overflow), 0);
        chk("rst latch", 32'(tx_latch), 0);
        chk("rst tx_data", 32'(tx_data), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data;
            ovf_clr = vecs[i].ovf_clr; tx_busy = vecs[i].busy;
            step();
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].full));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d latch", i), 32'(tx_latch), 32'(vecs[i].latch));
            if (vecs[i].chk_data)
                chk($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(vecs[i].data));
        end
        wr_en = 1'b0; ovf_clr = 1'b0;

        // Drain the remaining burst bytes through the serializer model
        for (int k = 2; k <= 16; k++) exp_q.push_back(8'(k));
        serve(15, "drain");

        // Write coinciding with a pop keeps count unchanged
        tx_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; wr_data = 8'(8'h61 + k);
            step();
        end
        chk("sim pre count", 32'(count), 5);
        wr_en = 1'b1; wr_data = 8'h66; tx_busy = 1'b0;
        step();
        wr_en = 1'b0;
        chk("sim count", 32'(count), 5);
        chk("sim latch", 32'(tx_latch), 1);
        chk("sim tx_data", 32'(tx_data), 32'h61);
        exp_q.delete();
        for (int k = 0; k < 5; k++) exp_q.push_back(8'(8'h62 + k));
        serve(5, "sim");

        // Pointer wrap: 40 bytes streamed through the 16-deep FIFO
        exp_q.delete(); feed_q.delete();
        for (int k = 0; k < 40; k++) begin
            feed_q.push_back(8'(k * 7 + 3));
            exp_q.push_back(8'(k * 7 + 3));
        end
        serve(40, "wrap");

        // Reset while full, overflowed and in WAIT
        tx_busy = 1'b0;
        wr_en = 1'b1; wr_data = 8'h50;
        step();
        wr_en = 1'b0;
        step();
        chk("mid latch", 32'(tx_latch), 1);
        step();
        tx_busy = 1'b1;
        for (int k = 0; k < 17; k++) begin
            wr_en = 1'b1; wr_data = 8'(8'h51 + k);
            step();
        end
        wr_en = 1'b0;
        chk("mid count", 32'(count), 16);
        chk("mid overflow", 32'(overflow), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst count", 32'(count), 0);
        chk("mrst empty", 32'(empty), 1);
        chk("mrst full", 32'(full), 0);
        chk("mrst overflow", 32'(overflow), 0);
        chk("mrst latch", 32'(tx_latch), 0);
        chk("mrst tx_data", 32'(tx_data), 0);
        step(); step(); step();
        tx_busy = 1'b0;
        nlat = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (tx_latch) nlat++;
        end
        chk("mrst no_latch", 32'(nlat), 0);
        wr_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        chk("post count", 32'(count), 1);
        chk("post latch0", 32'(tx_latch), 0);
        step();
        chk("post latch1", 32'(tx_latch), 1);
        chk("post tx_data", 32'(tx_data), 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
